i2c_sda_arbiter: RTL and testbench

- Shares one external open-collector SDA line between NUM_SLAVES on-chip I2C slave serializers on the same internal SCL/SDA bus.
- Sits between the I2C IO buffer and the slaves.
- Determines ownership from which slave ACKs the address byte, then drives only that slave's SDA output until STOP or repeated START.
- Flags address conflicts and releases the bus on an SCL-stuck-low watchdog.

---
 rtl/i2c_sda_arbiter_pkg.sv | 18 +
 rtl/i2c_bus_event_detector.sv | 32 +++
 rtl/i2c_sda_arbiter.sv | 160 ++++++++++++++++
 tb/tb_i2c_sda_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_sda_arbiter_pkg.sv
// Shared definitions for the I2C SDA arbiter: FSM state encodings, ACK bit position
// and default watchdog sizing.
package i2c_sda_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ADDR   = 2'd1,
        S_OWNED  = 2'd2,
        S_IGNORE = 2'd3
    } arb_state_e;

    // SCL rise number (counted from START) on which the address ACK is sampled
    localparam int I2C_ACK_BIT = 9;

    localparam int I2C_DEFAULT_TIMEOUT_CYCLES = 65535;
    localparam int I2C_DEFAULT_TIMEOUT_WIDTH  = 16;

endpackage

// File: rtl/i2c_bus_event_detector.sv
// Detects I2C START, STOP and SCL rising edges from synchronized SCL/SDA.
// Kept standalone so the slave serializers can reuse it.
module i2c_bus_event_detector
    import i2c_sda_arbiter_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic scl,
    input  logic sda_in,
    output logic start,
    output logic stop,
    output logic scl_rise
);

    logic prev_scl_q;
    logic prev_sda_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_scl_q <= 1'b1;
            prev_sda_q <= 1'b1;
        end else begin
            prev_scl_q <= scl;
            prev_sda_q <= sda_in;
        end
    end

    assign start    = scl && prev_sda_q && !sda_in;
    assign stop     = scl && !prev_sda_q && sda_in;
    assign scl_rise = scl && !prev_scl_q;

endmodule

// File: rtl/i2c_sda_arbiter.sv
// Shares one open-collector SDA line between NUM_SLAVES internal I2C slaves; the slave
// that ACKs the address owns SDA until STOP/Sr. Watchdog enabled by I2C_ARB_TIMEOUT_EN.
module i2c_sda_arbiter
    import i2c_sda_arbiter_pkg::*;
#(
    parameter int NUM_SLAVES     = 4,
    parameter int TIMEOUT_CYCLES = I2C_DEFAULT_TIMEOUT_CYCLES,
    parameter int TIMEOUT_WIDTH  = I2C_DEFAULT_TIMEOUT_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  scl,
    input  logic                  sda_in,
    input  logic [NUM_SLAVES-1:0] slave_sda_out,
    output logic                  sda_out,
    output logic [NUM_SLAVES-1:0] grant,
    output logic                  busy,
    output logic                  conflict,
    output logic                  timeout
);

    if (NUM_SLAVES < 1 || NUM_SLAVES > 8) begin : g_bad_num_slaves
        $error("i2c_sda_arbiter: NUM_SLAVES must be in 1..8");
    end
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_WIDTH < 1 || (TIMEOUT_CYCLES >> TIMEOUT_WIDTH) != 0) begin : g_bad_timeout
        $error("i2c_sda_arbiter: TIMEOUT_WIDTH cannot hold TIMEOUT_CYCLES");
    end

    arb_state_e            state_q, state_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic                  sda_out_q, sda_out_d;
    logic [NUM_SLAVES-1:0] grant_q, grant_d;
    logic                  busy_q, busy_d;
    logic                  conflict_q, conflict_d;
    logic                  timeout_q, timeout_d;

    logic                  bus_start;
    logic                  bus_stop;
    logic                  bus_scl_rise;
    logic                  ack_sample;
    logic [NUM_SLAVES-1:0] acked;
    logic [NUM_SLAVES-1:0] acked_low;
    logic                  acked_multi;
    logic                  wd_fire;

    i2c_bus_event_detector u_event_det (
        .clk      (clk),
        .reset    (reset),
        .scl      (scl),
        .sda_in   (sda_in),
        .start    (bus_start),
        .stop     (bus_stop),
        .scl_rise (bus_scl_rise)
    );

    // A slave ACKs by pulling low; lowest index wins, more than one ACKer is a conflict
    assign acked       = ~slave_sda_out;
    assign acked_low   = acked & (~acked + NUM_SLAVES'(1));
    assign acked_multi = |(acked & (acked - NUM_SLAVES'(1)));
    assign ack_sample  = (state_q == S_ADDR) && bus_scl_rise && !bus_start && !bus_stop
                         && (bit_cnt_q == 4'(I2C_ACK_BIT - 1));

`ifdef I2C_ARB_TIMEOUT_EN
    logic [TIMEOUT_WIDTH-1:0] wd_q, wd_d;

    always_comb begin
        wd_fire = busy_q && !scl && (wd_q == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1));
        wd_d    = (busy_q && !scl && !wd_fire) ? wd_q + TIMEOUT_WIDTH'(1) : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`else
    assign wd_fire = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= '0;
            sda_out_q  <= 1'b1;
            grant_q    <= '0;
            busy_q     <= 1'b0;
            conflict_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            sda_out_q  <= sda_out_d;
            grant_q    <= grant_d;
            busy_q     <= busy_d;
            conflict_q <= conflict_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus_start) state_d = S_ADDR;
            end
            default: begin
                if (bus_stop)        state_d = S_IDLE;
                else if (bus_start)  state_d = S_ADDR;
                else if (ack_sample) state_d = (acked == '0) ? S_IGNORE : S_OWNED;
            end
        endcase
        if (wd_fire) state_d = S_IDLE;
    end

    always_comb begin
        sda_out_d  = 1'b1;
        bit_cnt_d  = bit_cnt_q;
        grant_d    = grant_q;
        busy_d     = busy_q;
        conflict_d = 1'b0;
        timeout_d  = wd_fire;

        // Wired-AND while addressing so every slave can ACK; afterwards only the owner
        case (state_q)
            S_ADDR:  sda_out_d = &slave_sda_out;
            S_OWNED: sda_out_d = ~|(grant_q & ~slave_sda_out);
            default: sda_out_d = 1'b1;
        endcase

        if (bus_start)         bit_cnt_d = '0;
        else if (bus_scl_rise) bit_cnt_d = bit_cnt_q + 4'd1;

        if (state_q == S_IDLE) begin
            if (bus_start) busy_d = 1'b1;
        end else if (bus_stop) begin
            grant_d = '0;
            busy_d  = 1'b0;
        end else if (bus_start) begin
            grant_d = '0;
        end else if (ack_sample) begin
            grant_d    = acked_low;
            conflict_d = acked_multi;
        end

        if (wd_fire) begin
            sda_out_d = 1'b1;
            grant_d   = '0;
            busy_d    = 1'b0;
        end
    end

    assign sda_out  = sda_out_q;
    assign grant    = grant_q;
    assign busy     = busy_q;
    assign conflict = conflict_q;
    assign timeout  = timeout_q;

endmodule

// File: tb/tb_i2c_sda_arbiter.sv
// Scoreboard bench for i2c_sda_arbiter: transaction-level bus model pushes expected
// output changes and SDA bits; a monitor pops and compares as the DUT presents them.
module tb_i2c_sda_arbiter;

    localparam int NS     = 4;
    localparam int TO_CYC = 16;
`ifdef I2C_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk    = 1'b0;
    logic          reset  = 1'b1;
    logic          scl    = 1'b1;
    logic          sda_in = 1'b1;
    logic [NS-1:0] slave_sda_out = '1;
    logic          sda_out;
    logic [NS-1:0] grant;
    logic          busy;
    logic          conflict;
    logic          timeout;

    i2c_sda_arbiter #(
        .NUM_SLAVES     (NS),
        .TIMEOUT_CYCLES (TO_CYC),
        .TIMEOUT_WIDTH  (5)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .scl           (scl),
        .sda_in        (sda_in),
        .slave_sda_out (slave_sda_out),
        .sda_out       (sda_out),
        .grant         (grant),
        .busy          (busy),
        .conflict      (conflict),
        .timeout       (timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NS-1:0] grant;
        logic          busy;
        logic          conflict;
        logic          timeout;
    } evt_t;

    evt_t evt_q[$];
    logic sda_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Transaction-level bus view: who owns the bus and whether a transfer is open
    int   m_owner = -1;
    bit   m_busy  = 1'b0;

    function automatic evt_t mk_evt(logic [NS-1:0] g, logic b, logic c, logic t);
        evt_t e;
        e.grant = g; e.busy = b; e.conflict = c; e.timeout = t;
        return e;
    endfunction

    task automatic check_val(string nm, logic [NS-1:0] act, logic [NS-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %b, required %b", nm, act, exp);
        end
    endtask

    // Asynchronous reset must clear the outputs without any clock edge
    always @(negedge reset) begin
        #1;
        check_val("rst_sda_out",  {{(NS-1){1'b0}}, sda_out},  {{(NS-1){1'b0}}, 1'b1});
        check_val("rst_grant",    grant, '0);
        check_val("rst_busy",     {{(NS-1){1'b0}}, busy},     '0);
        check_val("rst_conflict", {{(NS-1){1'b0}}, conflict}, '0);
        check_val("rst_timeout",  {{(NS-1){1'b0}}, timeout},  '0);
    end

    evt_t prev_evt;
    logic prev_scl_m;

    always @(negedge clk) begin
        evt_t cur, exp_e;
        logic exp_s;
        cur = mk_evt(grant, busy, conflict, timeout);
        if (!reset) begin
            prev_evt   = '0;
            prev_scl_m = scl;
        end else begin
            if (scl && !prev_scl_m) begin
                n_vec++;
                if (sda_q.size() == 0) begin
                    n_err++;
                    $display("FAIL sda_bit: actual sda_out=%b at SCL rise, required no bit pending", sda_out);
                end else begin
                    exp_s = sda_q.pop_front();
                    if (sda_out !== exp_s) begin
                        n_err++;
                        $display("FAIL sda_bit: actual sda_out=%b, required %b (t=%0t)", sda_out, exp_s, $time);
                    end
                end
            end
            if (cur !== prev_evt) begin
                n_vec++;
                if (evt_q.size() == 0) begin
                    n_err++;
                    $display("FAIL out_change: actual grant=%b busy=%b conflict=%b timeout=%b, required no change",
                             cur.grant, cur.busy, cur.conflict, cur.timeout);
                end else begin
                    exp_e = evt_q.pop_front();
                    if (cur !== exp_e) begin
                        n_err++;
                        $display("FAIL out_change: actual grant=%b busy=%b conflict=%b timeout=%b, required grant=%b busy=%b conflict=%b timeout=%b (t=%0t)",
                                 cur.grant, cur.busy, cur.conflict, cur.timeout,
                                 exp_e.grant, exp_e.busy, exp_e.conflict, exp_e.timeout, $time);
                    end
                end
            end
            prev_evt   = cur;
            prev_scl_m = scl;
        end
    end

    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_bit(logic sda_v, logic [NS-1:0] slv, logic exp);
        scl = 1'b0;
        cyc(1);
        slave_sda_out = slv;
        sda_in        = sda_v;
        cyc(2);
        sda_q.push_back(exp);
        scl = 1'b1;
        cyc(3);
    endtask

    task automatic do_start();
        scl = 1'b0;
        cyc(1);
        sda_in = 1'b1;
        slave_sda_out = '1;
        cyc(1);
        sda_q.push_back(1'b1);
        scl = 1'b1;
        cyc(2);
        if (!m_busy || m_owner >= 0) evt_q.push_back(mk_evt('0, 1'b1, 1'b0, 1'b0));
        m_busy  = 1'b1;
        m_owner = -1;
        sda_in  = 1'b0;
        cyc(2);
    endtask

    task automatic do_stop();
        scl = 1'b0;
        cyc(1);
        sda_in = 1'b0;
        slave_sda_out = '1;
        cyc(1);
        sda_q.push_back(1'b1);
        scl = 1'b1;
        cyc(2);
        if (m_busy) evt_q.push_back(mk_evt('0, 1'b0, 1'b0, 1'b0));
        m_busy  = 1'b0;
        m_owner = -1;
        sda_in  = 1'b1;
        cyc(3);
    endtask

    task automatic send_addr(logic [7:0] a, logic [NS-1:0] ackers);
        logic [NS-1:0] low;
        bit            multi;
        for (int i = 7; i >= 0; i--) bus_bit(a[i], '1, 1'b1);
        if (ackers != '0) begin
            for (int i = NS - 1; i >= 0; i--) if (ackers[i]) m_owner = i;
            low = '0;
            low[m_owner] = 1'b1;
            multi = ($countones(ackers) > 1);
            evt_q.push_back(mk_evt(low, 1'b1, multi, 1'b0));
            if (multi) evt_q.push_back(mk_evt(low, 1'b1, 1'b0, 1'b0));
        end
        bus_bit(ackers == '0, ~ackers, ackers == '0);
    endtask

    function automatic logic [NS-1:0] data_drive(logic b, logic [NS-1:0] force_low, bit rnd);
        logic [NS-1:0] slv;
        slv = '1;
        for (int s = 0; s < NS; s++) begin
            if (force_low[s])  slv[s] = 1'b0;
            else if (rnd)      slv[s] = 1'($urandom_range(0, 1));
        end
        if (m_owner >= 0) slv[m_owner] = b;
        return slv;
    endfunction

    task automatic send_data(logic [7:0] d, logic [NS-1:0] force_low, bit rnd);
        logic [NS-1:0] slv;
        for (int i = 7; i >= 0; i--) begin
            slv = data_drive(d[i], force_low, rnd);
            bus_bit(&slv, slv, (m_owner >= 0) ? d[i] : 1'b1);
        end
        bus_bit(1'b0, '1, 1'b1);
    endtask

    task automatic hang_scl_low();
        logic [NS-1:0] slv;
        logic          exp;
        scl = 1'b0;
        cyc(1);
        slv = '1;
        slv[m_owner] = 1'b0;
        slave_sda_out = slv;
        sda_in = 1'b0;
        exp = 1'b0;
        if (TO_EN) begin
            evt_q.push_back(mk_evt('0, 1'b0, 1'b0, 1'b1));
            evt_q.push_back(mk_evt('0, 1'b0, 1'b0, 1'b0));
            m_busy  = 1'b0;
            m_owner = -1;
            exp     = 1'b1;
        end
        cyc(TO_CYC + 8);
        sda_q.push_back(exp);
        scl = 1'b1;
        cyc(3);
    endtask

    task automatic reset_mid_byte(logic [7:0] d);
        logic [NS-1:0] slv;
        for (int i = 7; i >= 4; i--) begin
            slv = data_drive(d[i], '0, 1'b0);
            bus_bit(&slv, slv, d[i]);
        end
        scl = 1'b0;
        cyc(1);
        slv = '1;
        slv[m_owner] = 1'b0;
        slave_sda_out = slv;
        sda_in = 1'b0;
        cyc(2);
        #2 reset = 1'b0;
        scl = 1'b1;
        sda_in = 1'b1;
        slave_sda_out = '1;
        m_busy  = 1'b0;
        m_owner = -1;
        cyc(2);
        reset = 1'b1;
        cyc(2);
    endtask

    initial begin
        logic [NS-1:0] ack;
        int            nb;
        #2 reset = 1'b0;
        cyc(3);
        reset = 1'b1;
        cyc(3);

        // Single ACKer, distractor slave 0 pulled low during data
        do_start();
        send_addr(8'hA0, 4'b0100);
        send_data(8'hA5, 4'b0001, 1'b0);
        send_data(8'h3C, 4'b0001, 1'b0);
        do_stop();

        // Two ACKers
        do_start();
        send_addr(8'h40, 4'b1010);
        send_data(8'($urandom), '0, 1'b1);
        do_stop();

        // Nobody ACKs: bus released even with slave 0 low
        do_start();
        send_addr(8'h7E, 4'b0000);
        send_data(8'hFF, 4'b0001, 1'b0);
        do_stop();

        // Repeated START hands ownership over
        do_start();
        send_addr(8'h10, 4'b0001);
        send_data(8'h96, '0, 1'b0);
        do_start();
        send_addr(8'hA3, 4'b1000);
        send_data(8'h5A, 4'b0111, 1'b0);
        do_stop();

        // SCL stuck low after grant
        do_start();
        send_addr(8'h22, 4'b0010);
        send_data(8'hC3, '0, 1'b0);
        hang_scl_low();
        do_stop();

        // Asynchronous reset in the middle of an owned byte
        do_start();
        send_addr(8'h30, 4'b0100);
        reset_mid_byte(8'hF7);

        for (int t = 0; t < 14; t++) begin
            if (m_busy && $urandom_range(0, 1) == 1) do_stop();
            do_start();
            ack = ($urandom_range(0, 3) == 0) ? '0 : NS'($urandom_range(1, (1 << NS) - 1));
            send_addr(8'($urandom), ack);
            nb = $urandom_range(0, 2);
            for (int b = 0; b < nb; b++) send_data(8'($urandom), NS'($urandom), 1'b1);
        end
        if (m_busy) do_stop();

        cyc(10);
        while (evt_q.size() != 0) begin
            evt_t e;
            e = evt_q.pop_front();
            n_vec++;
            n_err++;
            $display("FAIL out_change_missing: actual none, required grant=%b busy=%b conflict=%b timeout=%b",
                     e.grant, e.busy, e.conflict, e.timeout);
        end
        while (sda_q.size() != 0) begin
            logic s;
            s = sda_q.pop_front();
            n_vec++;
            n_err++;
            $display("FAIL sda_bit_missing: actual none, required %b", s);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
